// File: rtl/clock_meter_pkg.sv
// Shared types and default constants for the clock period meter.
// The state encoding is also visible on the top-level debug port.
package clock_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int          DEF_WIDTH      = 32;
    localparam int          DEF_LOCK_COUNT = 4;
    localparam int unsigned DEF_TIMEOUT    = 32'd67108864;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, followed by one delay flop.
// It flags both rising and falling edges of the synchronized level.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_edge,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level    = sync_q[SYNC_STAGES-1];
    assign sig_edge = sync_q[SYNC_STAGES-1] ^ delay_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the toggle interval of a slow signal and reports the divider value
// (half-period minus one), the full period, and a lock/timeout status.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int          WIDTH       = DEF_WIDTH,
    parameter int          SYNC_STAGES = 2,
    parameter int          LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] m_out,
    output logic [WIDTH-1:0] period_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout,
    output logic [1:0]       dbg_state
);

    localparam int               MW       = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] TO_LAST  = WIDTH'(TIMEOUT - 1);
    localparam logic [MW-1:0]    LOCK_SAT = MW'(LOCK_COUNT);
    localparam logic [MW-1:0]    LOCK_THR = MW'(LOCK_COUNT - 1);

    logic sig_edge;
    logic sig_level;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .sig_edge(sig_edge),
        .level   (sig_level)
    );

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [MW-1:0]    match_q, match_d;
    logic             first_q, first_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             meas_q, meas_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH:0]   sum;

    // cnt never exceeds TIMEOUT-1 < 2^WIDTH-1, so the extra bit holds the sum.
    assign sum = {1'b0, cnt_q} + {1'b0, prev_q} + (WIDTH+1)'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_q    <= '0;
            match_q   <= '0;
            first_q   <= 1'b0;
            m_q       <= '0;
            period_q  <= '0;
            meas_q    <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            match_q   <= match_d;
            first_q   <= first_d;
            m_q       <= m_d;
            period_q  <= period_d;
            meas_q    <= meas_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        match_d   = match_q;
        first_d   = first_q;
        m_d       = m_q;
        period_d  = period_q;
        meas_d    = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            match_d  = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    cnt_d = '0;
                    if (sig_edge) begin
                        timeout_d = 1'b0;
                        first_d   = 1'b1;
                        state_d   = MEASURE;
                    end
                end
                MEASURE: begin
                    if (sig_edge) begin
                        m_d      = cnt_q;
                        period_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                        prev_d   = cnt_q;
                        meas_d   = 1'b1;
                        cnt_d    = '0;
                        first_d  = 1'b0;
                        // The first half-period after acquisition is only a baseline.
                        if (first_q || (cnt_q != prev_q)) begin
                            match_d = '0;
                        end else if (match_q != LOCK_SAT) begin
                            match_d = match_q + 1'b1;
                        end
                        locked_d = (match_d >= LOCK_THR);
                    end else if (cnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        match_d   = '0;
                        cnt_d     = '0;
                        state_d   = ACQUIRE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign m_out      = m_q;
    assign period_out = period_q;
    assign meas_valid = meas_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: a divider model toggles sig_in, a reference
// model derives expected measurements from the recorded toggle times.
module tb_clock_period_meter;

    localparam int W       = 16;
    localparam int SYNC    = 2;
    localparam int LOCKN   = 4;
    localparam int TMO     = 100;
    localparam int LAG     = SYNC + 1;
    localparam int S_IDLE  = 0;
    localparam int S_ACQ   = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         sig_in = 1'b0;
    logic [W-1:0] m_out;
    logic [W-1:0] period_out;
    logic         meas_valid;
    logic         locked;
    logic         timeout;
    logic [1:0]   dbg_state;

    clock_period_meter #(
        .WIDTH      (W),
        .SYNC_STAGES(SYNC),
        .LOCK_COUNT (LOCKN),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .sig_in    (sig_in),
        .m_out     (m_out),
        .period_out(period_out),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Cycle counter and divider model.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit gen_on = 1'b0;
    int cur_m  = 4;
    int phase  = 0;
    int tog_q[$];

    always @(posedge clk) begin
        #1;
        if (gen_on) begin
            phase++;
            if (phase >= cur_m + 1) begin
                sig_in = ~sig_in;
                phase  = 0;
                tog_q.push_back(cyc);
            end
        end else begin
            phase = 0;
        end
    end

    // Reference model: each measurement reports the interval between the two
    // toggles that precede it by the fixed input lag.
    bit chk_en        = 1'b1;
    int meas_count    = 0;
    int last_meas_cyc = -1000;
    int last_half     = 0;
    int run           = 0;
    int k;
    int half;
    bit consec;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_meas_cyc = -1000;
            run           = 0;
        end else if (meas_valid) begin
            meas_count++;
            k = -1;
            foreach (tog_q[i]) if (tog_q[i] == cyc - LAG) k = i;
            if (chk_en) check("meas_src", 32'(k >= 1), 32'd1);
            if (k >= 1) begin
                half   = tog_q[k] - tog_q[k-1];
                consec = (last_meas_cyc == tog_q[k-1] + LAG);
                if (consec && half == last_half) run++;
                else run = 1;
                if (chk_en) begin
                    check("meas_m", 32'(m_out), 32'(half - 1));
                    if (consec) check("meas_period", 32'(period_out), 32'(half + last_half));
                    check("meas_locked", 32'(locked), 32'(run >= LOCKN));
                end
                last_half     = half;
                last_meas_cyc = cyc;
            end
        end
    end

    task automatic wait_meas(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (meas_count >= target) break;
        end
        check("wait_meas", 32'(meas_count >= target), 32'd1);
    endtask

    task automatic wait_toggle(input int budget);
        int sz;
        sz = tog_q.size();
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (tog_q.size() > sz) break;
        end
        check("wait_toggle", 32'(tog_q.size() > sz), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int mc;
        int m;
        int seen;
        int last_t;
        logic [W-1:0] mo;

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_m", 32'(m_out), 0);
        check("rst_period", 32'(period_out), 0);
        check("rst_valid", 32'(meas_valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_state", 32'(dbg_state), S_IDLE);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("idle_state", 32'(dbg_state), S_IDLE);
        check("idle_valid", 32'(meas_valid), 0);

        // Divider m=4: lock on the 4th measurement, one measurement per 5 cycles.
        cur_m  = 4;
        gen_on = 1'b1;
        enable = 1'b1;
        mc = meas_count;
        wait_meas(mc + 4, 200);
        check("m4_locked", 32'(locked), 1);
        check("m4_m", 32'(m_out), 4);
        check("m4_period", 32'(period_out), 10);
        mc = meas_count;
        repeat (50) @(posedge clk);
        #2;
        check("m4_rate", 32'(meas_count - mc), 10);

        // m=0 only has to keep running; then m=1 must measure and lock.
        chk_en = 1'b0;
        cur_m  = 0;
        repeat (40) @(posedge clk);
        cur_m = 1;
        repeat (10) @(posedge clk);
        #2;
        chk_en = 1'b1;
        mc = meas_count;
        wait_meas(mc + 6, 200);
        check("m1_m", 32'(m_out), 1);
        check("m1_period", 32'(period_out), 4);
        check("m1_locked", 32'(locked), 1);

        // Locked at m=9, then switch to m=19.
        cur_m = 9;
        mc = meas_count;
        wait_meas(mc + 6, 200);
        check("m9_locked", 32'(locked), 1);
        check("m9_m", 32'(m_out), 9);
        cur_m = 19;
        mc = meas_count;
        wait_meas(mc + 1, 100);
        check("m19_unlock", 32'(locked), 0);
        check("m19_m", 32'(m_out), 19);
        wait_meas(mc + 4, 200);
        check("m19_relock", 32'(locked), 1);
        check("m19_period", 32'(period_out), 40);

        // Randomized divider values.
        for (int r = 0; r < 3; r++) begin
            m = $urandom_range(2, 30);
            cur_m = m;
            mc = meas_count;
            wait_meas(mc + 6, 6 * (m + 1) + 60);
            check("rnd_m", 32'(m_out), 32'(m));
            check("rnd_period", 32'(period_out), 32'(2 * (m + 1)));
            check("rnd_locked", 32'(locked), 1);
        end

        // Static input: timeout exactly TMO cycles after the last count clear.
        wait_toggle(100);
        gen_on = 1'b0;
        last_t = tog_q[tog_q.size() - 1];
        seen = -1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (timeout) begin
                seen = cyc;
                break;
            end
        end
        check("to_cycle", 32'(seen), 32'(last_t + LAG + TMO));
        check("to_locked", 32'(locked), 0);
        check("to_state", 32'(dbg_state), S_ACQ);
        repeat (5) @(posedge clk);
        #2;
        check("to_sticky", 32'(timeout), 1);
        cur_m  = 5;
        mc     = meas_count;
        gen_on = 1'b1;
        wait_toggle(100);
        repeat (4) @(posedge clk);
        #2;
        check("to_clear", 32'(timeout), 0);
        check("to_discard", 32'(meas_count), 32'(mc));
        wait_meas(mc + 4, 200);
        check("to_relock", 32'(locked), 1);
        check("to_m", 32'(m_out), 5);

        // Reset pulse mid-count while locked.
        cur_m = 6;
        mc = meas_count;
        wait_meas(mc + 6, 300);
        wait_toggle(100);
        if (sig_in) wait_toggle(100);
        gen_on = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_locked", 32'(locked), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_m", 32'(m_out), 0);
        check("arst_period", 32'(period_out), 0);
        check("arst_locked", 32'(locked), 0);
        check("arst_valid", 32'(meas_valid), 0);
        check("arst_state", 32'(dbg_state), S_IDLE);
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        mc     = meas_count;
        gen_on = 1'b1;
        wait_toggle(100);
        wait_toggle(100);
        check("arst_discard", 32'(meas_count), 32'(mc));
        wait_meas(mc + 4, 200);
        check("arst_relock", 32'(locked), 1);
        check("arst_m6", 32'(m_out), 6);

        // Drop enable on the edge-detect cycle of a toggle.
        mo = m_out;
        mc = meas_count;
        wait_toggle(100);
        @(posedge clk);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #2;
        check("dis_valid", 32'(meas_valid), 0);
        check("dis_locked", 32'(locked), 0);
        check("dis_m", 32'(m_out), 32'(mo));
        check("dis_state", 32'(dbg_state), S_IDLE);
        check("dis_count", 32'(meas_count), 32'(mc));
        wait_toggle(100);
        enable = 1'b1;
        mc = meas_count;
        wait_toggle(100);
        check("reen_discard", 32'(meas_count), 32'(mc));
        wait_meas(mc + 4, 200);
        check("reen_relock", 32'(locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
